// File: rtl/spartan_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spartan_io_pkg
// Description : Shared address map and STATUS word layout for the I/O port
//               file and interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package spartan_io_pkg;

    localparam int DATA_W = 16;
    localparam int IRQ_W  = 16;

    // Reserved I/O addresses above the general-purpose ports
    localparam logic [3:0] IO_ADDR_INDIRECT = 4'hF;
    localparam logic [3:0] IO_ADDR_MASK     = 4'hE;
    localparam logic [3:0] IO_ADDR_STATUS   = 4'hD;

    // STATUS word bit positions
    localparam int STATUS_GIE_BIT = 15;
    localparam int STATUS_ID_LSB  = 8;
    localparam int STATUS_IRQ_BIT = 0;

    // Assemble the read-only STATUS word from its fields
    function automatic logic [DATA_W-1:0] status_word(
        input logic       gie,
        input logic [3:0] id,
        input logic       irq
    );
        logic [DATA_W-1:0] w;
        w                            = '0;
        w[STATUS_GIE_BIT]            = gie;
        w[STATUS_ID_LSB +: 4]        = id;
        w[STATUS_IRQ_BIT]            = irq;
        return w;
    endfunction

endpackage : spartan_io_pkg
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : Per-bit two-flop synchronizer followed by a previous-value
//               flop; produces a one-cycle pulse on each synchronized rise.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    // Synchronizer chain plus history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule : irq_sync_edge
`default_nettype wire

// File: rtl/io_int_controller.sv
`default_nettype none
// ============================================================================
// Module      : io_int_controller
// Description : Memory-mapped I/O port file and prioritized interrupt
//               controller on the shared 16-bit d_bus.
// Revision    : 1.0 - initial release
// ============================================================================
module io_int_controller
    import spartan_io_pkg::*;
#(
    parameter int          NUM_GP   = 13,
    parameter logic [15:0] VEC_BASE = 16'h0F00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             io_addr,
    input  logic                   io_addr_read,
    input  logic                   io_read,
    input  logic                   io_write,
    input  logic                   io_push,
    input  logic                   io_store_retaddr,
    input  logic                   io_push_retaddr,
    input  logic                   io_push_ints,
    input  logic                   io_push_int_addr,
    output logic                   io_interrupt,
    inout  wire  [15:0]            d_bus,
    input  logic [15:0]            irq_in,
    input  logic [16*NUM_GP-1:0]   port_in,
    output logic [16*NUM_GP-1:0]   port_out,
    output logic [NUM_GP-1:0]      port_wr_stb,
    output logic [NUM_GP-1:0]      port_rd_stb
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]           ind_addr_q,  ind_addr_d;
    logic [15:0]          rdbuf_q,     rdbuf_d;
    logic [15:0]          mask_q,      mask_d;
    logic [15:0]          retaddr_q,   retaddr_d;
    logic [15:0]          pending_q,   pending_d;
    logic                 gie_q,       gie_d;
    logic                 irq_q,       irq_d;
    logic [16*NUM_GP-1:0] port_out_q,  port_out_d;
    logic [NUM_GP-1:0]    wr_stb_q,    wr_stb_d;
    logic [NUM_GP-1:0]    rd_stb_q,    rd_stb_d;

    logic [15:0] irq_rise;
    logic [15:0] active;
    logic        has_win;
    logic [3:0]  cur_id;
    logic [15:0] clr_vec;
    logic [3:0]  ea;
    logic [15:0] rd_val;
    logic        bus_en;
    logic [15:0] bus_val;

    // ------------------------------------------------------------------
    // Interrupt source synchronization
    // ------------------------------------------------------------------
    irq_sync_edge #(
        .WIDTH (IRQ_W)
    ) u_irq_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (irq_in),
        .rise_o  (irq_rise)
    );

    assign active  = pending_q & mask_q;
    assign has_win = |active;

    // Priority encoder: lowest enabled pending index wins, 0 when none
    always_comb begin
        cur_id = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (active[i]) cur_id = 4'(i);
        end
    end

    // Acknowledge clears only the source that is winning right now
    assign clr_vec = (io_store_retaddr && has_win) ? (16'h0001 << cur_id) : 16'h0000;

    // Indirect addressing uses the register value from before this edge
    assign ea = (io_addr == IO_ADDR_INDIRECT) ? ind_addr_q : io_addr;

    // Read mux over the address map
    always_comb begin
        rd_val = 16'h0000;
        for (int i = 0; i < NUM_GP; i++) begin
            if (ea == 4'(i)) rd_val = port_in[16*i +: 16];
        end
        if (ea == IO_ADDR_MASK)   rd_val = mask_q;
        if (ea == IO_ADDR_STATUS) rd_val = status_word(gie_q, cur_id, irq_q);
    end

    // Next-state logic for the port file and interrupt registers
    always_comb begin
        ind_addr_d = ind_addr_q;
        rdbuf_d    = rdbuf_q;
        mask_d     = mask_q;
        retaddr_d  = retaddr_q;
        gie_d      = gie_q;
        port_out_d = port_out_q;
        wr_stb_d   = '0;
        rd_stb_d   = '0;
        // A new edge always survives a same-cycle acknowledge
        pending_d  = (pending_q & ~clr_vec) | irq_rise;
        irq_d      = gie_q & has_win;

        if (io_addr_read) ind_addr_d = d_bus[3:0];

        if (io_write) begin
            if (ea == IO_ADDR_MASK) mask_d = d_bus;
            for (int i = 0; i < NUM_GP; i++) begin
                if (ea == 4'(i)) begin
                    port_out_d[16*i +: 16] = d_bus;
                    wr_stb_d[i]            = 1'b1;
                end
            end
        end

        if (io_read) begin
            rdbuf_d = rd_val;
            for (int i = 0; i < NUM_GP; i++) begin
                if (ea == 4'(i)) rd_stb_d[i] = 1'b1;
            end
        end

        if (io_push_retaddr) gie_d = 1'b1;
        if (io_store_retaddr) begin
            retaddr_d = d_bus;
            gie_d     = 1'b0;
        end
    end

    // Register bank with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ind_addr_q <= '0;
            rdbuf_q    <= '0;
            mask_q     <= '0;
            retaddr_q  <= '0;
            pending_q  <= '0;
            gie_q      <= 1'b1;
            irq_q      <= 1'b0;
            port_out_q <= '0;
            wr_stb_q   <= '0;
            rd_stb_q   <= '0;
        end else begin
            ind_addr_q <= ind_addr_d;
            rdbuf_q    <= rdbuf_d;
            mask_q     <= mask_d;
            retaddr_q  <= retaddr_d;
            pending_q  <= pending_d;
            gie_q      <= gie_d;
            irq_q      <= irq_d;
            port_out_q <= port_out_d;
            wr_stb_q   <= wr_stb_d;
            rd_stb_q   <= rd_stb_d;
        end
    end

    // Bus driver selection in fixed priority order
    always_comb begin
        bus_en  = 1'b1;
        bus_val = 16'h0000;
        if (io_push)               bus_val = rdbuf_q;
        else if (io_push_retaddr)  bus_val = retaddr_q;
        else if (io_push_ints)     bus_val = active;
        else if (io_push_int_addr) bus_val = {VEC_BASE[15:4], cur_id};
        else                       bus_en  = 1'b0;
    end

    // Reset releases the bus immediately, independent of the clock
    assign d_bus = (bus_en && rst_n) ? bus_val : 16'hzzzz;

    assign io_interrupt = irq_q;
    assign port_out     = port_out_q;
    assign port_wr_stb  = wr_stb_q;
    assign port_rd_stb  = rd_stb_q;

endmodule : io_int_controller
`default_nettype wire

// File: tb/tb_io_int_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_int_controller
// Description : Self-checking bench for io_int_controller with a behavioural
//               reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_int_controller;

    localparam int          NGP = 13;
    localparam logic [15:0] VB  = 16'h0F00;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [3:0]           io_addr = '0;
    logic                 io_addr_read = 0, io_read = 0, io_write = 0, io_push = 0;
    logic                 io_store_retaddr = 0, io_push_retaddr = 0;
    logic                 io_push_ints = 0, io_push_int_addr = 0;
    logic                 io_interrupt;
    wire  [15:0]          d_bus;
    logic [15:0]          irq_in = '0;
    logic [16*NGP-1:0]    port_in = '0;
    logic [16*NGP-1:0]    port_out;
    logic [NGP-1:0]       port_wr_stb;
    logic [NGP-1:0]       port_rd_stb;

    logic                 tb_en = 1'b0;
    logic [15:0]          tb_drv = '0;
    assign d_bus = tb_en ? tb_drv : 16'hzzzz;

    always #5 clk = ~clk;

    io_int_controller #(.NUM_GP(NGP), .VEC_BASE(VB)) dut (
        .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_addr_read(io_addr_read),
        .io_read(io_read), .io_write(io_write), .io_push(io_push),
        .io_store_retaddr(io_store_retaddr), .io_push_retaddr(io_push_retaddr),
        .io_push_ints(io_push_ints), .io_push_int_addr(io_push_int_addr),
        .io_interrupt(io_interrupt), .d_bus(d_bus), .irq_in(irq_in),
        .port_in(port_in), .port_out(port_out),
        .port_wr_stb(port_wr_stb), .port_rd_stb(port_rd_stb)
    );

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    logic [16*NGP-1:0] m_port_out;
    logic [15:0]       m_mask, m_pending, m_retaddr, m_rdbuf;
    logic              m_gie, m_int;
    logic [3:0]        m_ind;
    logic [NGP-1:0]    m_wr, m_rd;
    logic [15:0]       h0, h1, h2;   // irq_in as sampled at the last three edges

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lowest_id(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_port_out = '0; m_mask = '0; m_pending = '0; m_retaddr = '0; m_rdbuf = '0;
        m_gie = 1'b1; m_int = 1'b0; m_ind = '0; m_wr = '0; m_rd = '0;
        h0 = '0; h1 = '0; h2 = '0;
    endtask

    function automatic logic [15:0] exp_bus();
        logic [15:0] act;
        act = m_pending & m_mask;
        if (io_push)               return m_rdbuf;
        else if (io_push_retaddr)  return m_retaddr;
        else if (io_push_ints)     return act;
        else                       return {VB[15:4], 4'(lowest_id(act))};
    endfunction

    // Advance the model by one clock edge using the inputs held at that edge
    task automatic model_step();
        logic [15:0] act, rise, rd;
        logic [3:0]  ea;
        int          id;
        act  = m_pending & m_mask;
        id   = lowest_id(act);
        ea   = (io_addr == 4'hF) ? m_ind : io_addr;
        rise = h1 & ~h2;
        m_wr = '0;
        m_rd = '0;
        rd   = 16'h0000;
        if (int'(ea) < NGP)  rd = port_in[int'(ea)*16 +: 16];
        else if (ea == 4'hE) rd = m_mask;
        else if (ea == 4'hD) rd = 16'(m_gie) * 16'h8000 + 16'(id) * 16'h0100 + 16'(m_int);
        m_int = m_gie && (act != 16'h0);
        if (io_read) begin
            m_rdbuf = rd;
            if (int'(ea) < NGP) m_rd[ea] = 1'b1;
        end
        if (io_write) begin
            if (int'(ea) < NGP) begin
                m_port_out[int'(ea)*16 +: 16] = tb_drv;
                m_wr[ea] = 1'b1;
            end else if (ea == 4'hE) m_mask = tb_drv;
        end
        if (io_addr_read) m_ind = tb_drv[3:0];
        if (io_store_retaddr && act != 16'h0) m_pending[id] = 1'b0;
        m_pending = m_pending | rise;
        if (io_push_retaddr) m_gie = 1'b1;
        if (io_store_retaddr) begin
            m_retaddr = tb_drv;
            m_gie     = 1'b0;
        end
        h2 = h1; h1 = h0; h0 = irq_in;
    endtask

    task automatic idle();
        io_addr_read = 0; io_read = 0; io_write = 0; io_push = 0;
        io_store_retaddr = 0; io_push_retaddr = 0; io_push_ints = 0; io_push_int_addr = 0;
        tb_en = 0;
    endtask

    // One clock: check the bus during the cycle, then registered outputs after the edge
    task automatic do_cycle();
        logic push, probe;
        push  = io_push | io_push_retaddr | io_push_ints | io_push_int_addr;
        probe = 1'b0;
        if (!push && !tb_en) begin
            tb_en  = 1'b1;
            tb_drv = 16'($urandom);
            probe  = 1'b1;
        end
        #1;
        if (push)       check_val("bus_drv", d_bus, exp_bus());
        else if (probe) check_val("bus_hiz", d_bus, tb_drv);
        @(posedge clk);
        model_step();
        #1;
        check_val("irq", io_interrupt, m_int);
        check_val("wr_stb", port_wr_stb, m_wr);
        check_val("rd_stb", port_rd_stb, m_rd);
        check_val("port_out", port_out, m_port_out);
        if (probe) tb_en = 1'b0;
    endtask

    task automatic op_write(input logic [3:0] a, input logic [15:0] d);
        idle(); io_write = 1; io_addr = a; tb_en = 1; tb_drv = d; do_cycle(); idle();
    endtask

    task automatic op_read(input logic [3:0] a);
        idle(); io_read = 1; io_addr = a; do_cycle(); idle();
    endtask

    task automatic op_addr_read(input logic [15:0] d);
        idle(); io_addr_read = 1; tb_en = 1; tb_drv = d; do_cycle(); idle();
    endtask

    task automatic op_store(input logic [15:0] d);
        idle(); io_store_retaddr = 1; tb_en = 1; tb_drv = d; do_cycle(); idle();
    endtask

    // sel: 0 push, 1 push_retaddr, 2 push_ints, 3 push_int_addr
    task automatic op_push(input int sel, input string tag, input logic [15:0] exp);
        idle();
        case (sel)
            0:       io_push = 1;
            1:       io_push_retaddr = 1;
            2:       io_push_ints = 1;
            default: io_push_int_addr = 1;
        endcase
        #1;
        check_val(tag, d_bus, exp);
        do_cycle();
        idle();
    endtask

    task automatic op_push_rand(input int sel);
        idle();
        case (sel)
            0:       io_push = 1;
            1:       io_push_retaddr = 1;
            2:       io_push_ints = 1;
            default: io_push_int_addr = 1;
        endcase
        do_cycle();
        idle();
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        apply_reset();
        do_cycle();
        check_val("rst_irq", io_interrupt, 1'b0);
        check_val("rst_port_out", port_out, '0);

        // Direct write
        op_write(4'd3, 16'hBEEF);
        check_val("wr_port3", port_out[48 +: 16], 16'hBEEF);
        check_val("wr_stb3", port_wr_stb, 13'h0008);
        do_cycle();
        check_val("wr_stb_clear", port_wr_stb, '0);

        // Read then push
        port_in[5*16 +: 16] = 16'h1234;
        op_read(4'd5);
        do_cycle();
        op_push(0, "push_rdbuf", 16'h1234);
        do_cycle();

        // Indirect write
        op_addr_read(16'h0007);
        op_write(4'hF, 16'h00AA);
        check_val("ind_port7", port_out[7*16 +: 16], 16'h00AA);

        // Interrupt latency and vectoring
        op_write(4'hE, 16'h0030);
        irq_in[5] = 1'b1;
        do_cycle();
        irq_in[4] = 1'b1; irq_in[5] = 1'b0;
        do_cycle();
        irq_in[4] = 1'b0;
        do_cycle();
        check_val("irq_lat3", io_interrupt, 1'b0);
        do_cycle();
        check_val("irq_lat4", io_interrupt, 1'b1);
        repeat (3) do_cycle();
        op_push(3, "vec_addr4", 16'h0F04);
        op_push(2, "ints_30", 16'h0030);

        // Acknowledge, return and re-assert
        op_store(16'h0123);
        repeat (2) do_cycle();
        check_val("ack_irq_low", io_interrupt, 1'b0);
        op_push(2, "ints_20", 16'h0020);
        op_push(1, "retaddr", 16'h0123);
        repeat (2) do_cycle();
        check_val("irq_reassert", io_interrupt, 1'b1);
        op_push(3, "vec_addr5", 16'h0F05);

        // Same-cycle set and clear of pending[2]
        op_write(4'hE, 16'h0004);
        irq_in[2] = 1'b1;
        repeat (5) do_cycle();
        irq_in[2] = 1'b0;
        repeat (3) do_cycle();
        irq_in[2] = 1'b1;
        do_cycle();
        do_cycle();
        op_store(16'h0456);
        op_push(2, "set_wins", 16'h0004);

        // Reset in the middle of a push
        idle();
        io_push_int_addr = 1;
        #1;
        check_val("push_pre_rst", d_bus, 16'h0F02);
        rst_n = 1'b0;
        #1;
        tb_en = 1'b1; tb_drv = 16'h5A5A;
        #1;
        check_val("rst_bus_hiz", d_bus, 16'h5A5A);
        model_reset();
        irq_in = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        op_write(4'hE, 16'hFFFF);
        op_push(2, "rst_pend0", 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int op;
            irq_in = irq_in ^ 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) port_in[$urandom_range(0, NGP-1)*16 +: 16] = 16'($urandom);
            op = $urandom_range(0, 11);
            case (op)
                0, 1: op_write(4'($urandom_range(0, 15)), 16'($urandom));
                2:    op_write(4'hE, 16'($urandom));
                3:    op_read(4'($urandom_range(0, 15)));
                4:    op_addr_read(16'($urandom));
                5:    op_store(16'($urandom));
                6, 7, 8, 9: op_push_rand(op - 6);
                default: begin idle(); do_cycle(); end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_io_int_controller
`default_nettype wire

// File: doc/io_int_controller.md
# io_int_controller

Memory-mapped I/O port file and prioritized interrupt controller that sits directly downstream of the control unit on the shared 16-bit `d_bus`. It executes the control unit's `io_*` strobes: it latches or drives port data, return addresses, pending-interrupt words and vector addresses. It synchronizes external interrupt lines and raises `io_interrupt` back to the control unit.

## Interface
Parameters:
- `NUM_GP` — default 13 — number of general-purpose ports, at addresses 0..NUM_GP-1 (max 13).
- `VEC_BASE` — default 16'h0F00 — vector base address; bits [3:0] are ignored.

Ports:
- `clk` — in — 1 — system clock, rising edge.
- `rst_n` — in — 1 — reset; asynchronous, active-low.
- `io_addr` — in — 4 — direct port address, from the control unit.
- `io_addr_read` — in — 1 — capture `d_bus[3:0]` into the indirect address register.
- `io_read` — in — 1 — sample the selected port input into the read buffer.
- `io_write` — in — 1 — write `d_bus` to the selected port.
- `io_push` — in — 1 — drive the read buffer onto `d_bus`.
- `io_store_retaddr` — in — 1 — capture `d_bus` as the return address and acknowledge the interrupt.
- `io_push_retaddr` — in — 1 — drive the return address onto `d_bus` and re-enable interrupts.
- `io_push_ints` — in — 1 — drive `pending & mask` onto `d_bus`.
- `io_push_int_addr` — in — 1 — drive the vector of the highest-priority enabled pending source onto `d_bus`.
- `io_interrupt` — out — 1 — interrupt request to the control unit; registered.
- `d_bus` — inout — 16 — shared data bus; high-Z unless a push strobe is high.
- `irq_in` — in — 16 — asynchronous interrupt sources; rising-edge sensitive.
- `port_in` — in — 16*NUM_GP — external port input words.
- `port_out` — out — 16*NUM_GP — registered port output words.
- `port_wr_stb` — out — NUM_GP — one-cycle pulse, one cycle after a write.
- `port_rd_stb` — out — NUM_GP — one-cycle pulse, one cycle after a read.

## Operation
- Effective address: `ea = (io_addr == 4'hF) ? ind_addr : io_addr`. `ind_addr` is loaded by `io_addr_read`.
- Address map:
  - 0..NUM_GP-1: GP ports.
  - 14: MASK register, read/write.
  - 13: STATUS, read-only: `{gie, 3'b0, cur_id, 4'b0, 3'b0, io_interrupt}`.
  - All other addresses: writes ignored, reads return 0.
- Interrupt sources:
  - `irq_in` passes through a 2-flop synchronizer plus a previous-value flop.
  - A rising edge on bit k sets `pending[k]`.
- Priority: the lowest index among `pending & mask` wins. `cur_id` is the winning index; it is 0 when there is no winner.
- `io_interrupt` is registered as `gie & |(pending & mask)`.
- `io_store_retaddr`:
  - `retaddr <= d_bus`.
  - `gie <= 0`.
  - Clears `pending[cur_id]` as evaluated in that same cycle.
- `io_push_retaddr`: drives `retaddr` onto the bus; `gie <= 1` on that clock edge.
- `io_push_int_addr`: drives `{VEC_BASE[15:4], cur_id}`.
- Bus drive:
  - Combinational from the strobes, priority `io_push` > `io_push_retaddr` > `io_push_ints` > `io_push_int_addr`.
  - High-Z when no push strobe is high.
  - Multiple push strobes high at once is a control-unit error; the priority rule still applies.
- Reset values:
  - All outputs 0; `d_bus` high-Z.
  - `pending`, `mask`, `retaddr`, `ind_addr`, `rdbuf`, `port_out` all 0.
  - `gie` = 1.

## Timing
- All strobes are single-cycle pulses registered by the control unit. The block samples them on the next rising `clk`.
- Pushes drive `d_bus` during the strobe cycle; the consumer latches at the end of that cycle.
- Read is 1-cycle latency: `io_read` in cycle N puts `rdbuf` valid from N+1. `io_push` is expected at N+1 or later.
- Write: `port_out` and `port_wr_stb` update at the clock edge ending cycle N. `port_wr_stb` is high for exactly cycle N+1.
- IRQ latency: an `irq_in` rise to `io_interrupt` high takes 4 clocks (2 sync, 1 edge, 1 output register).
- Same-cycle set and clear of `pending[k]`: set wins; the new edge is not lost.
- MASK write and a new edge on the same cycle: the pending bit is still recorded. The mask only gates the request.
- `io_addr_read` together with `io_read`/`io_write` using `io_addr = 4'hF`: the old `ind_addr` is used.
- A `rst_n` assertion mid-sequence aborts immediately: the bus releases asynchronously and all pending interrupts are dropped.

## Structure
- Shared package `spartan_io_pkg`: address constants `IO_ADDR_INDIRECT=4'hF`, `IO_ADDR_MASK=4'hE`, `IO_ADDR_STATUS=4'hD`, and the STATUS bit positions.
- One sub-module, `irq_sync_edge`: a per-bit 2-flop synchronizer with rising-edge detect. It is instantiated 16 bits wide.
- The priority encoder and port file are inline.

## Test plan
- Reset, then `io_write` of 16'hBEEF to `io_addr=3` → `port_out[3]=16'hBEEF`, `port_wr_stb[3]` high for exactly one cycle, all other outputs 0.
- `port_in[5]=16'h1234`, `io_read` with `io_addr=5`, then `io_push` → `d_bus=16'h1234` during the push cycle, high-Z before and after.
- `io_addr_read` with `d_bus=16'h0007`, then `io_write` of 16'h00AA with `io_addr=4'hF` → `port_out[7]=16'h00AA`.
- MASK=16'h0030; pulse `irq_in[5]` then `irq_in[4]` → `io_interrupt` high 4 clocks after the first rise; `io_push_int_addr` drives 16'h0F04; `io_push_ints` drives 16'h0030.
- `io_store_retaddr` with `d_bus=16'h0123` → `io_interrupt` low, pending=16'h0020. `io_push_retaddr` then drives 16'h0123, after which `io_interrupt` re-asserts for source 5.
- Rising edge on `irq_in[2]` in the same cycle that clears `pending[2]`, then `rst_n` low mid-push → pending[2] stays set; on reset the bus goes high-Z immediately and pending=0.
